// File: rtl/key_cmd_conditioner.sv
// key_cmd_conditioner: turns four raw operator keys into clean,
// state-gated single-cycle command pulses for the control FSM.

module key_debounce #(
   parameter int DEBOUNCE_CNT   = 1000000,
   parameter int CNT_W          = 20,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic sys_clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam logic             IDLE_RAW = KEY_ACTIVE_LOW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic             meta;
   logic             sync;
   logic             pressed;
   logic             level_q;
   logic [CNT_W-1:0] cnt;

   // Sync chain parks at the released level so reset never fakes a press.
   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= IDLE_RAW;
         sync <= IDLE_RAW;
      end else begin
         meta <= raw;
         sync <= meta;
      end
   end

   assign pressed = sync ^ KEY_ACTIVE_LOW;

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         level   <= 1'b0;
         level_q <= 1'b0;
      end else begin
         level_q <= level;
         if (pressed == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= pressed;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   assign press = level & ~level_q;

endmodule

module key_cmd_conditioner #(
   parameter int DEBOUNCE_CNT   = 1000000,
   parameter int CNT_W          = 20,
   parameter bit KEY_ACTIVE_LOW = 1'b1
) (
   input  logic       sys_clk,
   input  logic       rst_n,
   input  logic       key_power_raw,
   input  logic       key_save_raw,
   input  logic       key_fetch_raw,
   input  logic       key_finish_raw,
   input  logic       ctrl_idle,
   input  logic       fetch_active,
   output logic       start_power,
   output logic       start_save,
   output logic       start_fetch,
   output logic       finish_fetch,
   output logic [3:0] key_level,
   output logic [7:0] drop_cnt
);

   logic [3:0] raw;
   logic [3:0] level;
   logic [3:0] press;
   logic [2:0] grant;
   logic       finish_ok;
   logic [2:0] n_start;
   logic [2:0] n_drop;
   logic [8:0] drop_sum;

   assign raw = {key_finish_raw, key_fetch_raw, key_save_raw, key_power_raw};

   for (genvar k = 0; k < 4; k++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CNT   (DEBOUNCE_CNT),
         .CNT_W          (CNT_W),
         .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
      ) u_db (
         .sys_clk (sys_clk),
         .rst_n   (rst_n),
         .raw     (raw[k]),
         .level   (level[k]),
         .press   (press[k])
      );
   end

   assign key_level = level;

   // Power beats save beats fetch; every losing or gated press is dropped.
   always_comb begin
      grant   = '0;
      n_start = 3'(press[0]) + 3'(press[1]) + 3'(press[2]);
      n_drop  = n_start;
      if (ctrl_idle) begin
         n_drop = n_start - 3'(|n_start);
         case (1'b1)
            press[0]: grant = 3'b001;
            press[1]: grant = 3'b010;
            press[2]: grant = 3'b100;
            default:  grant = 3'b000;
         endcase
      end
      finish_ok = press[3] & fetch_active;
      if (press[3] & ~fetch_active)
         n_drop = n_drop + 3'd1;
      drop_sum = {1'b0, drop_cnt} + {6'b0, n_drop};
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         start_power  <= 1'b0;
         start_save   <= 1'b0;
         start_fetch  <= 1'b0;
         finish_fetch <= 1'b0;
         drop_cnt     <= '0;
      end else begin
         start_power  <= grant[0];
         start_save   <= grant[1];
         start_fetch  <= grant[2];
         finish_fetch <= finish_ok;
         drop_cnt     <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      end
   end

endmodule

// File: tb/tb_key_cmd_conditioner.sv
// Scoreboard bench for key_cmd_conditioner: directed scenarios plus
// random key/control traffic against a behavioural model.

module tb_key_cmd_conditioner;

   localparam int DB = 8;
   localparam int CW = 4;

   typedef struct packed {
      int         cyc;
      logic [3:0] pulses;
   } exp_t;

   logic       sys_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] press = '0;
   logic       ctrl_idle = 1'b1;
   logic       fetch_active = 1'b0;
   logic       key_power_raw;
   logic       key_save_raw;
   logic       key_fetch_raw;
   logic       key_finish_raw;
   logic       start_power;
   logic       start_save;
   logic       start_fetch;
   logic       finish_fetch;
   logic [3:0] key_level;
   logic [7:0] drop_cnt;

   assign key_power_raw  = ~press[0];
   assign key_save_raw   = ~press[1];
   assign key_fetch_raw  = ~press[2];
   assign key_finish_raw = ~press[3];

   key_cmd_conditioner #(
      .DEBOUNCE_CNT   (DB),
      .CNT_W          (CW),
      .KEY_ACTIVE_LOW (1'b1)
   ) dut (
      .sys_clk        (sys_clk),
      .rst_n          (rst_n),
      .key_power_raw  (key_power_raw),
      .key_save_raw   (key_save_raw),
      .key_fetch_raw  (key_fetch_raw),
      .key_finish_raw (key_finish_raw),
      .ctrl_idle      (ctrl_idle),
      .fetch_active   (fetch_active),
      .start_power    (start_power),
      .start_save     (start_save),
      .start_fetch    (start_fetch),
      .finish_fetch   (finish_fetch),
      .key_level      (key_level),
      .drop_cnt       (drop_cnt)
   );

   initial forever #10 sys_clk = ~sys_clk;

   int n_chk = 0;
   int n_fail = 0;
   int cyc = 0;
   exp_t q[$];

   logic [3:0] m_level = '0;
   logic [3:0] d1 = '0;
   logic [3:0] d2 = '0;
   logic [3:0] pend = '0;
   int run[4];
   int m_drop = 0;
   int pulse_cnt[4];
   int last_pulse[4];

   task automatic check(string name, int act, int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic hold(int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Model: a key level is accepted once the synchronised key has
   // disagreed with it for DB consecutive edges; commands resolve an edge later.
   always @(posedge sys_clk) begin
      int   nst;
      int   win;
      int   drops;
      logic [3:0] ex;
      cyc++;
      if (!rst_n) begin
         m_level = '0;
         d1      = '0;
         d2      = '0;
         pend    = '0;
         m_drop  = 0;
         for (int k = 0; k < 4; k++) run[k] = 0;
         q.delete();
      end else begin
         if (pend != 0) begin
            ex    = '0;
            nst   = $countones(pend[2:0]);
            drops = nst;
            if (ctrl_idle && nst > 0) begin
               win = 0;
               for (int k = 2; k >= 0; k--) if (pend[k]) win = k;
               ex[win] = 1'b1;
               drops   = nst - 1;
            end
            if (pend[3]) begin
               if (fetch_active) ex[3] = 1'b1;
               else drops++;
            end
            m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
            if (ex != 0) q.push_back('{cyc: cyc, pulses: ex});
         end
         pend = '0;
         for (int k = 0; k < 4; k++) begin
            if (d2[k] != m_level[k]) begin
               run[k]++;
               if (run[k] == DB) begin
                  m_level[k] = d2[k];
                  run[k]     = 0;
                  pend[k]    = d2[k];
               end
            end else begin
               run[k] = 0;
            end
         end
         d2 = d1;
         d1 = press;
      end
   end

   initial begin : monitor
      logic [3:0] pv;
      exp_t       e;
      for (int k = 0; k < 4; k++) begin
         pulse_cnt[k]  = 0;
         last_pulse[k] = -1;
      end
      forever begin
         @(posedge sys_clk);
         #1;
         pv = {finish_fetch, start_fetch, start_save, start_power};
         for (int k = 0; k < 4; k++) begin
            if (pv[k]) begin
               pulse_cnt[k]++;
               last_pulse[k] = cyc;
            end
         end
         if (pv != 0) begin
            if (q.size() == 0) begin
               check("unexpected_pulse", int'(pv), 0);
            end else begin
               e = q.pop_front();
               check("pulse_cycle", cyc, e.cyc);
               check("pulse_vector", int'(pv), int'(e.pulses));
            end
         end else if (q.size() != 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            check("missed_pulse", 0, int'(e.pulses));
         end
         check("key_level", int'(key_level), int'(m_level));
         check("drop_cnt", int'(drop_cnt), m_drop);
      end
   end

   initial begin : stim
      int c0;
      int tmr[4];
      hold(3);
      check("rst_pulses", int'({finish_fetch, start_fetch, start_save, start_power}), 0);
      check("rst_level", int'(key_level), 0);
      check("rst_drop", int'(drop_cnt), 0);
      rst_n = 1'b1;
      hold(5);

      // Clean press; the sampling edge counts as the first of DB+3 edges.
      press[0] = 1'b1;
      c0 = cyc + 1;
      hold(50);
      check("t1_power_count", pulse_cnt[0], 1);
      check("t1_power_latency", last_pulse[0], c0 + DB + 2);
      check("t1_level", int'(key_level[0]), 1);
      check("t1_drop", int'(drop_cnt), 0);
      press[0] = 1'b0;
      hold(15);

      for (int i = 0; i < 8; i++) begin
         press[1] = ~press[1];
         hold(5);
      end
      check("t2_no_bounce_pulse", pulse_cnt[1], 0);
      press[1] = 1'b1;
      c0 = cyc + 1;
      hold(30);
      check("t2_save_count", pulse_cnt[1], 1);
      check("t2_save_latency", last_pulse[1], c0 + DB + 2);
      check("t2_drop", int'(drop_cnt), 0);
      press[1] = 1'b0;
      hold(15);

      press[0] = 1'b1;
      press[2] = 1'b1;
      hold(20);
      check("t3_power_count", pulse_cnt[0], 2);
      check("t3_fetch_count", pulse_cnt[2], 0);
      check("t3_drop", int'(drop_cnt), 1);
      press = '0;
      hold(15);

      ctrl_idle = 1'b0;
      press[2] = 1'b1;
      hold(15);
      check("t4_gated_fetch", pulse_cnt[2], 0);
      check("t4_drop_fetch", int'(drop_cnt), 2);
      press[2] = 1'b0;
      hold(15);
      ctrl_idle = 1'b1;
      fetch_active = 1'b1;
      press[3] = 1'b1;
      hold(15);
      check("t4_finish_count", pulse_cnt[3], 1);
      press[3] = 1'b0;
      hold(15);
      fetch_active = 1'b0;
      press[3] = 1'b1;
      hold(15);
      check("t4_finish_gated", pulse_cnt[3], 1);
      check("t4_drop_finish", int'(drop_cnt), 3);
      press[3] = 1'b0;
      hold(15);

      ctrl_idle = 1'b0;
      repeat (300) begin
         press[1] = 1'b1;
         hold(10);
         press[1] = 1'b0;
         hold(10);
      end
      hold(5);
      check("t5_drop_sat", int'(drop_cnt), 255);
      check("t5_save_count", pulse_cnt[1], 1);

      ctrl_idle = 1'b1;
      press[0] = 1'b1;
      hold(7);
      rst_n = 1'b0;
      #1;
      check("t6_rst_pulses", int'({finish_fetch, start_fetch, start_save, start_power}), 0);
      check("t6_rst_level", int'(key_level), 0);
      check("t6_rst_drop", int'(drop_cnt), 0);
      hold(3);
      rst_n = 1'b1;
      c0 = cyc + 1;
      hold(20);
      check("t6_power_count", pulse_cnt[0], 3);
      check("t6_power_latency", last_pulse[0], c0 + DB + 2);

      for (int k = 0; k < 4; k++) tmr[k] = 0;
      repeat (4000) begin
         @(negedge sys_clk);
         for (int k = 0; k < 4; k++) begin
            if (tmr[k] == 0) begin
               press[k] = ~press[k];
               tmr[k] = ($urandom_range(0, 2) == 0) ?
                        int'($urandom_range(9, 30)) : int'($urandom_range(1, 10));
            end else begin
               tmr[k]--;
            end
         end
         ctrl_idle    = ($urandom_range(0, 3) != 0);
         fetch_active = ($urandom_range(0, 1) != 0);
      end
      press = '0;
      ctrl_idle = 1'b1;
      hold(30);
      check("scoreboard_drained", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
